lowx_mem_arbiter: RTL and testbench
===================================

# lowx_mem_arbiter

Two-requester arbiter between the instruction cache and data cache miss ports and the single lower-level memory port. It accepts one outstanding line request at a time, latches the winning requester's request, issues it downstream with a valid/ready handshake, and steers the returned response back to the granted requester. It sits between `icache`/`dcache` and the external memory interface, just below the fetch and memory stages.

## Interface
Parameters:
- XLEN, 32, address width
- BLK_SIZE, 128, cache line / transfer data width in bits

Ports:
- clk_i  in  1  core clock
- rst_ni  in  1  one clock; reset is synchronous and active-high
- ic_req_valid_i  in  1  icache miss request; held high until ic_res_valid_o
- ic_req_addr_i  in  XLEN  icache request line address
- ic_req_uncached_i  in  1  icache request is uncached
- ic_res_valid_o  out  1  one-cycle response strobe to icache
- ic_res_data_o  out  BLK_SIZE  response line to icache
- dc_req_valid_i  in  1  dcache request; held high until dc_res_valid_o
- dc_req_addr_i  in  XLEN  dcache request line address
- dc_req_rw_i  in  1  1 = write (writeback), 0 = read
- dc_req_wdata_i  in  BLK_SIZE  writeback line
- dc_req_uncached_i  in  1  dcache request is uncached
- dc_res_valid_o  out  1  one-cycle response strobe to dcache (reads and write acks)
- dc_res_data_o  out  BLK_SIZE  response line to dcache
- mem_req_valid_o  out  1  downstream request valid
- mem_req_ready_i  in  1  downstream accepts request
- mem_req_addr_o  out  XLEN  latched address
- mem_req_rw_o  out  1  latched rw (always 0 for icache)
- mem_req_wdata_o  out  BLK_SIZE  latched write data (0 for icache)
- mem_req_uncached_o  out  1  latched uncached flag
- mem_res_valid_i  in  1  downstream response valid
- mem_res_data_i  in  BLK_SIZE  downstream response data
- grant_o  out  2  one-hot owner: bit0 icache, bit1 dcache; 00 when idle
- busy_o  out  1  state is not IDLE

## Operation
- FSM states: IDLE, ISSUE, WAIT.
- IDLE: if any req_valid high, select winner, latch addr/rw/wdata/uncached and owner; go ISSUE. Otherwise stay.
- ISSUE: mem_req_valid_o = 1, request fields stable; on mem_req_ready_i go WAIT.
- WAIT: mem_req_valid_o = 0; on mem_res_valid_i assert owner's res_valid_o for that cycle, with res_data_o = mem_res_data_i; go IDLE.
- Non-owner res_valid_o is always 0; res_data_o of both ports is driven from mem_res_data_i (qualified only by res_valid_o).
- mem_res_valid_i outside WAIT (including in ISSUE) is ignored.
- Request inputs are sampled only in IDLE; changes in ISSUE/WAIT have no effect.
- icache requests force mem_req_rw_o = 0 and mem_req_wdata_o = 0.
- Simultaneous requests resolve per Configuration. A single requester wins unconditionally.

## Timing
- Reset: state IDLE; mem_req_valid_o=0, addr/rw/wdata/uncached regs=0, grant_o=00, busy_o=0, both res_valid_o=0, last-served flag = dcache.
- Request high in IDLE at cycle N: mem_req_valid_o and grant_o are registered and high at N+1.
- Response at cycle M in WAIT: res_valid_o high in cycle M (combinational). State is IDLE at M+1. The next grant is latched at M+1 and issued at M+2.
- Requester drops valid on the edge after seeing its res_valid_o, so it is not re-granted spuriously.
- Back-pressure: ISSUE holds all mem_req_* stable for any number of cycles while mem_req_ready_i = 0.
- Reset mid-transaction: the FSM returns to IDLE the next cycle and the in-flight response is discarded.

## Configuration
- LOWX_ARB_ROUND_ROBIN_EN defined: on a tie, grant the requester not served last. The last-served flag updates on each grant and resets to dcache, so the first tie goes to icache.
- Not defined: fixed priority. dcache always wins ties and the last-served flag is not implemented.

## Test plan
- icache alone, addr 0x4000_0040, ready after 3 cycles, response 2 cycles later with data 0xA5…A5 -> mem_req_valid_o held 3 cycles with stable addr; ic_res_valid_o pulses once with 0xA5…A5; dc_res_valid_o stays 0.
- dcache write, addr 0x4000_1000, wdata 0x1234…, rw=1 -> mem_req_rw_o=1 and mem_req_wdata_o matches; dc_res_valid_o pulses on the ack.
- Both valid in the same cycle, five back-to-back transactions -> with the macro, grants alternate ic, dc, ic, dc, ic. Without the macro, dcache is served first and icache only after dcache drops valid.
- Stray mem_res_valid_i in IDLE and in ISSUE -> no res_valid_o, state unchanged.
- rst_ni asserted in WAIT, then late mem_res_valid_i -> outputs at reset values, no response forwarded, busy_o=0.
- Requester changes addr while in WAIT -> mem_req_addr_o keeps the latched value.

Source files
------------

// File: rtl/lowx_mem_arbiter.sv
// lowx_mem_arbiter
//
// Arbitrates the icache and dcache miss ports onto one lower-level memory
// port. One line request is outstanding at a time. In IDLE the winning
// requester's fields are latched. ISSUE presents them downstream until the
// memory accepts them. WAIT then forwards the single response beat back to
// the requester that was granted.
//
// Optional feature: define LOWX_ARB_ROUND_ROBIN_EN to resolve simultaneous
// requests in favour of the requester not served last. When it is undefined,
// ties use fixed priority and dcache wins.
//
// Ports
//   clk_i, rst_ni        clock; synchronous active-high reset (despite the name)
//   ic_req_*             icache miss request (valid, addr, uncached)
//   ic_res_*             icache response strobe and line
//   dc_req_*             dcache request (valid, addr, rw, wdata, uncached)
//   dc_res_*             dcache response strobe and line (read data or write ack)
//   mem_req_*            downstream request, valid/ready handshake, latched fields
//   mem_res_*            downstream response beat
//   grant_o              one-hot owner {dcache, icache}; 00 when idle
//   busy_o               arbiter is not in IDLE
module lowx_mem_arbiter #(
  parameter int XLEN     = 32,
  parameter int BLK_SIZE = 128
) (
  input  logic                clk_i,
  input  logic                rst_ni,
  input  logic                ic_req_valid_i,
  input  logic [XLEN-1:0]     ic_req_addr_i,
  input  logic                ic_req_uncached_i,
  output logic                ic_res_valid_o,
  output logic [BLK_SIZE-1:0] ic_res_data_o,
  input  logic                dc_req_valid_i,
  input  logic [XLEN-1:0]     dc_req_addr_i,
  input  logic                dc_req_rw_i,
  input  logic [BLK_SIZE-1:0] dc_req_wdata_i,
  input  logic                dc_req_uncached_i,
  output logic                dc_res_valid_o,
  output logic [BLK_SIZE-1:0] dc_res_data_o,
  output logic                mem_req_valid_o,
  input  logic                mem_req_ready_i,
  output logic [XLEN-1:0]     mem_req_addr_o,
  output logic                mem_req_rw_o,
  output logic [BLK_SIZE-1:0] mem_req_wdata_o,
  output logic                mem_req_uncached_o,
  input  logic                mem_res_valid_i,
  input  logic [BLK_SIZE-1:0] mem_res_data_i,
  output logic [1:0]          grant_o,
  output logic                busy_o
);

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT} state_t;

  state_t              state_q, state_d;
  logic [XLEN-1:0]     addr_q;
  logic                rw_q;
  logic [BLK_SIZE-1:0] wdata_q;
  logic                uncached_q;
  logic [1:0]          grant_q;
  logic                any_req;
  logic                pick_dc;
  logic                latch_en;
  logic                res_fire;

  assign any_req  = ic_req_valid_i | dc_req_valid_i;
  assign latch_en = (state_q == IDLE) && any_req;
  // Only a beat that arrives in WAIT is a response; beats at other times are dropped.
  assign res_fire = (state_q == WAIT) && mem_res_valid_i;

`ifdef LOWX_ARB_ROUND_ROBIN_EN
  // last_dc_q records who was granted most recently. On a tie the other requester wins.
  logic last_dc_q;

  always_comb begin
    pick_dc = dc_req_valid_i;
    if (ic_req_valid_i && dc_req_valid_i) pick_dc = ~last_dc_q;
  end

  always_ff @(posedge clk_i) begin
    if (rst_ni)        last_dc_q <= 1'b1;
    else if (latch_en) last_dc_q <= pick_dc;
  end
`else
  // Fixed priority: dcache takes any tie.
  assign pick_dc = dc_req_valid_i;
`endif

  always_comb begin
    state_d         = state_q;
    mem_req_valid_o = 1'b0;
    ic_res_valid_o  = 1'b0;
    dc_res_valid_o  = 1'b0;
    busy_o          = (state_q != IDLE);
    case (state_q)
      IDLE:  if (any_req) state_d = ISSUE;
      ISSUE: begin
        mem_req_valid_o = 1'b1;
        if (mem_req_ready_i) state_d = WAIT;
      end
      WAIT: begin
        ic_res_valid_o = mem_res_valid_i & grant_q[0];
        dc_res_valid_o = mem_res_valid_i & grant_q[1];
        if (mem_res_valid_i) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_ni) begin
      state_q    <= IDLE;
      addr_q     <= '0;
      rw_q       <= 1'b0;
      wdata_q    <= '0;
      uncached_q <= 1'b0;
      grant_q    <= 2'b00;
    end else begin
      state_q <= state_d;
      if (latch_en) begin
        grant_q <= pick_dc ? 2'b10 : 2'b01;
        if (pick_dc) begin
          addr_q     <= dc_req_addr_i;
          rw_q       <= dc_req_rw_i;
          wdata_q    <= dc_req_wdata_i;
          uncached_q <= dc_req_uncached_i;
        end else begin
          // icache only ever reads, so rw and wdata are forced to zero.
          addr_q     <= ic_req_addr_i;
          rw_q       <= 1'b0;
          wdata_q    <= '0;
          uncached_q <= ic_req_uncached_i;
        end
      end else if (res_fire) begin
        grant_q <= 2'b00;
      end
    end
  end

  assign mem_req_addr_o     = addr_q;
  assign mem_req_rw_o       = rw_q;
  assign mem_req_wdata_o    = wdata_q;
  assign mem_req_uncached_o = uncached_q;
  assign grant_o            = grant_q;
  // Response data is broadcast to both ports. The res_valid strobes qualify it.
  assign ic_res_data_o      = mem_res_data_i;
  assign dc_res_data_o      = mem_res_data_i;

endmodule

// File: tb/tb_lowx_mem_arbiter.sv
// Testbench for lowx_mem_arbiter. It uses randomized requesters and memory,
// and a transaction-level reference model.
module tb_lowx_mem_arbiter;
  localparam int XLEN = 32;
  localparam int BLK  = 128;

  logic            clk = 1'b0;
  logic            rst;
  logic            ic_v, ic_unc, ic_res_v;
  logic [XLEN-1:0] ic_addr;
  logic [BLK-1:0]  ic_res_d;
  logic            dc_v, dc_rw, dc_unc, dc_res_v;
  logic [XLEN-1:0] dc_addr;
  logic [BLK-1:0]  dc_wd, dc_res_d;
  logic            mreq_v, mreq_rdy, mreq_rw, mreq_unc;
  logic [XLEN-1:0] mreq_addr;
  logic [BLK-1:0]  mreq_wd;
  logic            mres_v;
  logic [BLK-1:0]  mres_d;
  logic [1:0]      grant;
  logic            busy;

  lowx_mem_arbiter #(.XLEN(XLEN), .BLK_SIZE(BLK)) dut (
    .clk_i(clk), .rst_ni(rst),
    .ic_req_valid_i(ic_v), .ic_req_addr_i(ic_addr), .ic_req_uncached_i(ic_unc),
    .ic_res_valid_o(ic_res_v), .ic_res_data_o(ic_res_d),
    .dc_req_valid_i(dc_v), .dc_req_addr_i(dc_addr), .dc_req_rw_i(dc_rw),
    .dc_req_wdata_i(dc_wd), .dc_req_uncached_i(dc_unc),
    .dc_res_valid_o(dc_res_v), .dc_res_data_o(dc_res_d),
    .mem_req_valid_o(mreq_v), .mem_req_ready_i(mreq_rdy), .mem_req_addr_o(mreq_addr),
    .mem_req_rw_o(mreq_rw), .mem_req_wdata_o(mreq_wd), .mem_req_uncached_o(mreq_unc),
    .mem_res_valid_i(mres_v), .mem_res_data_i(mres_d),
    .grant_o(grant), .busy_o(busy)
  );

  always #5 clk = ~clk;

  int n_chk = 0;
  int n_bad = 0;

  task automatic check_eq(input string tag, input logic [BLK-1:0] got, input logic [BLK-1:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Reference model: the transaction in flight (owner 0 none, 1 icache, 2 dcache),
  // whether memory has accepted it, and the fields captured at grant time.
  int              m_owner;
  bit              m_acc;
  bit              m_last_dc;
  logic [XLEN-1:0] m_addr;
  logic            m_rw, m_unc;
  logic [BLK-1:0]  m_wd;
  int              ic_served, dc_served, ties;
  bit              seen_ic, seen_dc;

  function automatic logic [BLK-1:0] rnd_line();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  initial begin
    bit       win_dc;
    bit       e_ic, e_dc;
    logic [1:0] e_grant;
    rst = 1'b1; ic_v = 0; ic_addr = '0; ic_unc = 0;
    dc_v = 0; dc_addr = '0; dc_rw = 0; dc_wd = '0; dc_unc = 0;
    mreq_rdy = 0; mres_v = 0; mres_d = '0;
    m_owner = 0; m_acc = 0; m_last_dc = 1; m_addr = '0; m_rw = 0; m_unc = 0; m_wd = '0;
    ic_served = 0; dc_served = 0; ties = 0;
    @(posedge clk); #1;

    for (int cyc = 0; cyc < 4000; cyc++) begin
      @(negedge clk);
      e_ic    = (m_owner == 1) && m_acc && mres_v;
      e_dc    = (m_owner == 2) && m_acc && mres_v;
      e_grant = (m_owner == 1) ? 2'b01 : (m_owner == 2) ? 2'b10 : 2'b00;
      check_eq("busy", busy, m_owner != 0);
      check_eq("grant", grant, e_grant);
      check_eq("mreq_valid", mreq_v, (m_owner != 0) && !m_acc);
      check_eq("mreq_addr", mreq_addr, m_addr);
      check_eq("mreq_rw", mreq_rw, m_rw);
      check_eq("mreq_wdata", mreq_wd, m_wd);
      check_eq("mreq_unc", mreq_unc, m_unc);
      check_eq("ic_res_valid", ic_res_v, e_ic);
      check_eq("dc_res_valid", dc_res_v, e_dc);
      if (e_ic) check_eq("ic_res_data", ic_res_d, mres_d);
      if (e_dc) check_eq("dc_res_data", dc_res_d, mres_d);
      seen_ic = ic_res_v;
      seen_dc = dc_res_v;

      @(posedge clk);
      if (rst) begin
        m_owner = 0; m_acc = 0; m_last_dc = 1;
        m_addr = '0; m_rw = 0; m_unc = 0; m_wd = '0;
      end else if (m_owner == 0) begin
        if (ic_v || dc_v) begin
          if (ic_v && dc_v) begin
            ties++;
`ifdef LOWX_ARB_ROUND_ROBIN_EN
            win_dc = !m_last_dc;
`else
            win_dc = 1'b1;
`endif
          end else begin
            win_dc = dc_v;
          end
          m_last_dc = win_dc;
          m_owner   = win_dc ? 2 : 1;
          m_acc     = 0;
          m_addr    = win_dc ? dc_addr : ic_addr;
          m_rw      = win_dc ? dc_rw : 1'b0;
          m_wd      = win_dc ? dc_wd : '0;
          m_unc     = win_dc ? dc_unc : ic_unc;
        end
      end else if (!m_acc) begin
        if (mreq_rdy) m_acc = 1;
      end else if (mres_v) begin
        if (m_owner == 1) ic_served++; else dc_served++;
        m_owner = 0;
        m_acc   = 0;
      end

      #1;
      rst = (cyc < 2) || ($urandom_range(0, 149) == 0);
      // Requesters hold valid until their response, then drop it for at least a cycle.
      if (seen_ic) ic_v = 0;
      else if (!ic_v) begin
        ic_v = ($urandom_range(0, 1) == 0);
        ic_addr = $urandom & ~32'hF;
        ic_unc = $urandom_range(0, 1);
      end else if (m_owner != 0) begin
        ic_addr = $urandom & ~32'hF;
        ic_unc = $urandom_range(0, 1);
      end
      if (seen_dc) dc_v = 0;
      else if (!dc_v) begin
        dc_v = ($urandom_range(0, 1) == 0);
        dc_addr = $urandom & ~32'hF;
        dc_rw = $urandom_range(0, 1);
        dc_wd = rnd_line();
        dc_unc = $urandom_range(0, 1);
      end else if (m_owner != 0) begin
        dc_addr = $urandom & ~32'hF;
        dc_rw = $urandom_range(0, 1);
        dc_wd = rnd_line();
      end
      // Memory: random back-pressure, and response beats at any time (stray ones included).
      mreq_rdy = ($urandom_range(0, 2) == 0);
      mres_v   = ($urandom_range(0, 3) == 0);
      mres_d   = rnd_line();
    end

    check_eq("ic_served_some", ic_served != 0, 1'b1);
    check_eq("dc_served_some", dc_served != 0, 1'b1);
    check_eq("ties_seen", ties != 0, 1'b1);
    $display("test done: total=%0d bad=%0d", n_chk, n_bad);
    $finish;
  end
endmodule
